lab3_sweep_ctrl: RTL

- Sequencer that exhaustively exercises one 4-input, 1-output combinational function block, such as the lab 3 gate-level function.
- It drives all 16 {w,x,y,z} vectors in ascending order and waits a programmable settle time per vector.
- It samples the function output, builds the 16-bit truth table and compares it against an expected table.
- It sits beside the function instance as an on-chip self-check and reports pass/fail through a start/done handshake.

---
 rtl/lab3_sweep_ctrl_if.sv | 33 +++
 rtl/lab3_sweep_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/lab3_sweep_ctrl_if.sv
// Signals between the sweep controller and its surroundings: the start/abort
// handshake, the function under test, and the captured results.
interface lab3_sweep_ctrl_if;
    logic        CL2947MP_start;
    logic        CL2947MP_abort;
    logic        CL2947MP_outa;
    logic        CL2947MP_w;
    logic        CL2947MP_x;
    logic        CL2947MP_y;
    logic        CL2947MP_z;
    logic        CL2947MP_busy;
    logic        CL2947MP_done;
    logic [15:0] CL2947MP_table;
    logic        CL2947MP_pass;
    logic [4:0]  CL2947MP_mis_cnt;
    logic        CL2947MP_fail_valid;
    logic [3:0]  CL2947MP_fail_idx;

    // master: the requester plus the function block; slave: the sweep controller
    modport master (
        output CL2947MP_start, CL2947MP_abort, CL2947MP_outa,
        input  CL2947MP_w, CL2947MP_x, CL2947MP_y, CL2947MP_z,
        input  CL2947MP_busy, CL2947MP_done, CL2947MP_table, CL2947MP_pass,
        input  CL2947MP_mis_cnt, CL2947MP_fail_valid, CL2947MP_fail_idx
    );

    modport slave (
        input  CL2947MP_start, CL2947MP_abort, CL2947MP_outa,
        output CL2947MP_w, CL2947MP_x, CL2947MP_y, CL2947MP_z,
        output CL2947MP_busy, CL2947MP_done, CL2947MP_table, CL2947MP_pass,
        output CL2947MP_mis_cnt, CL2947MP_fail_valid, CL2947MP_fail_idx
    );
endinterface

// File: rtl/lab3_sweep_ctrl.sv
// Exhaustive 16-vector sweep of a 4-input combinational function, capturing
// its truth table and comparing it against a golden table.
module lab3_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECTED      = 16'h2812
) (
    input  logic              CL2947MP_clk,
    input  logic              CL2947MP_rst_n,
    lab3_sweep_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam state_t     HOLD_STATE  = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_t      state;
    logic [3:0]  idx;
    logic [3:0]  cnt;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] tbl;
    logic [4:0]  mis_cnt;
    logic        fail_valid;
    logic [3:0]  fail_idx;

    logic        mismatch;
    logic [4:0]  mis_cnt_inc;

    assign mismatch    = (bus.CL2947MP_outa != EXPECTED[idx]);
    assign mis_cnt_inc = mis_cnt + 5'(mismatch);

    // NOTE: every register, results included, is in the async reset so a
    // mid-sweep reset leaves no stale table or counts behind.
    always_ff @(posedge CL2947MP_clk or negedge CL2947MP_rst_n) begin
        if (!CL2947MP_rst_n) begin
            state      <= IDLE;
            idx        <= 4'd0;
            cnt        <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            tbl        <= 16'h0000;
            mis_cnt    <= 5'd0;
            fail_valid <= 1'b0;
            fail_idx   <= 4'd0;
        end else begin
            // NOTE: non-blocking throughout, so every decision below reads the
            // values from before this edge (e.g. fail_valid on the first miss).
            done <= 1'b0;
            if (busy && bus.CL2947MP_abort) begin
                state <= IDLE;
                busy  <= 1'b0;
                idx   <= 4'd0;
                pass  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.CL2947MP_start) begin
                            tbl        <= 16'h0000;
                            mis_cnt    <= 5'd0;
                            fail_valid <= 1'b0;
                            fail_idx   <= 4'd0;
                            pass       <= 1'b0;
                            idx        <= 4'd0;
                            busy       <= 1'b1;
                            cnt        <= SETTLE_LOAD;
                            state      <= HOLD_STATE;
                        end
                    end
                    SETTLE: begin
                        if (cnt <= 4'd1) state <= SAMPLE;
                        else             cnt   <= cnt - 4'd1;
                    end
                    SAMPLE: begin
                        tbl[idx] <= bus.CL2947MP_outa;
                        if (mismatch) begin
                            mis_cnt <= mis_cnt_inc;
                            if (!fail_valid) begin
                                fail_valid <= 1'b1;
                                fail_idx   <= idx;
                            end
                        end
                        if (idx == 4'd15) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            pass  <= (mis_cnt_inc == 5'd0);
                            idx   <= 4'd0;
                        end else begin
                            idx   <= idx + 4'd1;
                            cnt   <= SETTLE_LOAD;
                            state <= HOLD_STATE;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // The index is zero whenever no sweep is running, so it drives the vector directly.
    assign {bus.CL2947MP_w, bus.CL2947MP_x, bus.CL2947MP_y, bus.CL2947MP_z} = idx;
    assign bus.CL2947MP_busy       = busy;
    assign bus.CL2947MP_done       = done;
    assign bus.CL2947MP_table      = tbl;
    assign bus.CL2947MP_pass       = pass;
    assign bus.CL2947MP_mis_cnt    = mis_cnt;
    assign bus.CL2947MP_fail_valid = fail_valid;
    assign bus.CL2947MP_fail_idx   = fail_idx;
endmodule
